// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter: FSM encoding and default widths.
package toggle_period_meter_pkg;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_MEAS = 2'b10
    } state_t;

endpackage

// File: rtl/toggle_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus a both-edge pulse
// formed from the synchronized level and one delayed copy of it.
module toggle_period_meter_sync_edge_detect
    import toggle_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;

    // Synchronizer chain followed by the edge-detect delay flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_r[SYNC_STAGES-1] ^ dly_r;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the half-period of an asynchronous toggle input in clk cycles and
// delivers each result on a valid/ready output with sticky overrun/timeout flags.
module toggle_period_meter
    import toggle_period_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             i_toggle,
    input  logic [CNT_W-1:0] i_timeout_th,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment so a stalled input never wraps into a short period
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic             edge_s;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] res_s;
    logic             res_vld_s;
    logic             tmo_evt_s;
    logic [CNT_W-1:0] half_r, half_s;
    logic             valid_r, valid_s;
    logic             ovr_r, ovr_s;
    logic             tmo_r, tmo_s;

    toggle_period_meter_sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (i_toggle),
        .edge_pulse(edge_s)
    );

    // FSM next state, counter and result/timeout event generation
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        res_s     = CNT_ZERO;
        res_vld_s = 1'b0;
        tmo_evt_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_ARM;
                    cnt_s   = CNT_ZERO;
                end
                ST_ARM: begin
                    if (edge_s) begin
                        state_s = ST_MEAS;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s   = CNT_ZERO;
                    end
                end
                ST_MEAS: begin
                    // An edge on the threshold cycle still yields a result
                    if (edge_s) begin
                        res_s     = cnt_r;
                        res_vld_s = 1'b1;
                        cnt_s     = CNT_ONE;
                    end else if ((i_timeout_th != CNT_ZERO) && (cnt_r == i_timeout_th)) begin
                        tmo_evt_s = 1'b1;
                        state_s   = ST_ARM;
                        cnt_s     = CNT_ZERO;
                    end else begin
                        cnt_s     = sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output handshake: load on free or simultaneously-drained slot, else flag overrun
    always_comb begin
        half_s  = half_r;
        valid_s = valid_r;
        ovr_s   = ovr_r;
        tmo_s   = tmo_r;
        if (!enable) begin
            valid_s = 1'b0;
            ovr_s   = 1'b0;
            tmo_s   = 1'b0;
        end else begin
            if (res_vld_s) begin
                if (!valid_r || i_ready) begin
                    half_s  = res_s;
                    valid_s = 1'b1;
                end else begin
                    ovr_s   = 1'b1;
                end
            end else if (valid_r && i_ready) begin
                valid_s = 1'b0;
            end else begin
                valid_s = valid_r;
            end
            if (tmo_evt_s) begin
                tmo_s = 1'b1;
            end else begin
                tmo_s = tmo_r;
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            half_r  <= CNT_ZERO;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            half_r  <= half_s;
            valid_r <= valid_s;
            ovr_r   <= ovr_s;
            tmo_r   <= tmo_s;
        end
    end

    assign o_half_period = half_r;
    assign o_valid       = valid_r;
    assign o_overrun     = ovr_r;
    assign o_timeout     = tmo_r;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter: clk-synchronous toggle patterns with
// hand-computed half-periods, handshake, overrun, timeout and reset/enable cases.
module tb_toggle_period_meter;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             i_toggle;
    logic [CNT_W-1:0] i_timeout_th;
    logic [CNT_W-1:0] o_half_period;
    logic             o_valid;
    logic             i_ready;
    logic             o_overrun;
    logic             o_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    always #5 clk = ~clk;

    toggle_period_meter #(
        .CNT_W(CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .i_toggle     (i_toggle),
        .i_timeout_th (i_timeout_th),
        .o_half_period(o_half_period),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable  = 1'b0;
        i_ready = 1'b1;
        repeat (5) step();
    endtask

    // A toggle applied before posedge k is seen by the FSM at posedge k+2,
    // i.e. at loop index i+2 when toggled at the top of iteration i.
    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        i_toggle     = 1'b0;
        i_ready      = 1'b1;
        i_timeout_th = 32'd0;
        repeat (3) step();
        check("rst_half", o_half_period, 32'd0);
        check("rst_valid", o_valid, 32'd0);
        check("rst_ovr", o_overrun, 32'd0);
        check("rst_tmo", o_timeout, 32'd0);
        #2 reset_n = 1'b1;

        // threshold 10, always ready
        go_idle();
        enable  = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) i_toggle = ~i_toggle;
            step();
            if (o_valid) begin
                n_valid++;
                check("t10_half", o_half_period, 32'd10);
            end
            if (i == 12) check("t10_first_valid", o_valid, 32'd1);
            if (i == 13) check("t10_valid_drop", o_valid, 32'd0);
            if (i % 10 == 9) begin
                check("t10_ovr", o_overrun, 32'd0);
                check("t10_tmo", o_timeout, 32'd0);
            end
        end
        check("t10_count", n_valid, 32'd5);

        // threshold 1: back-to-back results
        go_idle();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_toggle = ~i_toggle;
            step();
            if (i < 3) begin
                check("t1_valid_lo", o_valid, 32'd0);
            end else begin
                check("t1_valid_hi", o_valid, 32'd1);
                check("t1_half", o_half_period, 32'd1);
            end
        end
        check("t1_ovr", o_overrun, 32'd0);

        // threshold 5, consumer stalled then released
        go_idle();
        i_ready = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 15) i_ready = 1'b1;
            if (i % 5 == 0) i_toggle = ~i_toggle;
            step();
            if (i == 6) check("t5_pre_valid", o_valid, 32'd0);
            if (i == 7) begin
                check("t5_valid", o_valid, 32'd1);
                check("t5_half", o_half_period, 32'd5);
                check("t5_ovr_lo", o_overrun, 32'd0);
            end
            if (i == 12) begin
                check("t5_ovr_hi", o_overrun, 32'd1);
                check("t5_held_valid", o_valid, 32'd1);
                check("t5_held_half", o_half_period, 32'd5);
            end
            if (i == 15) check("t5_drain", o_valid, 32'd0);
            if (i == 17) begin
                check("t5_next_valid", o_valid, 32'd1);
                check("t5_next_half", o_half_period, 32'd5);
                check("t5_ovr_sticky", o_overrun, 32'd1);
            end
            if (i == 18) check("t5_next_drain", o_valid, 32'd0);
        end

        // timeout 20 after a single edge, then edges every 7
        go_idle();
        check("idle_ovr_clr", o_overrun, 32'd0);
        i_timeout_th = 32'd20;
        enable       = 1'b1;
        for (int i = 0; i < 56; i++) begin
            if (i == 0 || i == 30 || i == 37 || i == 44 || i == 51) i_toggle = ~i_toggle;
            step();
            if (i == 21) check("to_not_yet", o_timeout, 32'd0);
            if (i == 22) check("to_set", o_timeout, 32'd1);
            if (i == 32) check("to_arm_no_result", o_valid, 32'd0);
            if (i == 39 || i == 46 || i == 53) begin
                check("to_p7_valid", o_valid, 32'd1);
                check("to_p7_half", o_half_period, 32'd7);
                check("to_sticky", o_timeout, 32'd1);
            end
        end
        enable = 1'b0;
        step();
        check("to_en_clr", o_timeout, 32'd0);
        check("to_en_valid", o_valid, 32'd0);
        check("to_en_half_hold", o_half_period, 32'd7);

        // edge coinciding with counter == threshold 8
        go_idle();
        i_timeout_th = 32'd8;
        enable       = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i % 8 == 0) i_toggle = ~i_toggle;
            step();
            if (i == 10 || i == 26) begin
                check("eq_valid", o_valid, 32'd1);
                check("eq_half", o_half_period, 32'd8);
                check("eq_tmo", o_timeout, 32'd0);
            end
        end
        check("eq_tmo_end", o_timeout, 32'd0);

        // async reset mid-measurement
        go_idle();
        i_timeout_th = 32'd0;
        i_ready      = 1'b0;
        enable       = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i % 6 == 0) i_toggle = ~i_toggle;
            step();
            if (i == 8) check("rm_half", o_half_period, 32'd6);
            if (i == 14) check("rm_ovr", o_overrun, 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("rm_async_half", o_half_period, 32'd0);
        check("rm_async_valid", o_valid, 32'd0);
        check("rm_async_ovr", o_overrun, 32'd0);
        i_toggle = 1'b0;
        i_ready  = 1'b1;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 6) i_toggle = ~i_toggle;
            step();
            if (i == 7) check("rm_one_edge", o_valid, 32'd0);
            if (i == 8) begin
                check("rm_two_edge_valid", o_valid, 32'd1);
                check("rm_two_edge_half", o_half_period, 32'd6);
            end
        end

        // enable dropped mid-measurement
        go_idle();
        i_ready = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) i_toggle = ~i_toggle;
            step();
            if (i == 6) check("em_half", o_half_period, 32'd4);
            if (i == 10) check("em_ovr", o_overrun, 32'd1);
        end
        enable = 1'b0;
        step();
        check("em_valid_clr", o_valid, 32'd0);
        check("em_ovr_clr", o_overrun, 32'd0);
        check("em_half_hold", o_half_period, 32'd4);
        enable  = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 4) i_toggle = ~i_toggle;
            step();
            if (i == 5) check("em_one_edge", o_valid, 32'd0);
            if (i == 6) begin
                check("em_two_edge_valid", o_valid, 32'd1);
                check("em_two_edge_half", o_half_period, 32'd4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
Receive-side companion to the team's threshold-counter toggle generator. Synchronizes an external toggle input and detects each edge. Measures the half-period in clk cycles between consecutive edges and presents each result on a valid/ready output. Used to close the loop on LED/blink outputs and to check divided clocks in self-test.

Parameters:
CNT_W, 32, width of the period counter, result bus and timeout threshold
SYNC_STAGES, 2, number of input synchronizer flops (minimum 2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = measure; 0 = return to IDLE and clear the counter, o_valid, o_overrun and o_timeout
i_toggle  input  1  asynchronous toggle signal to be measured
i_timeout_th  input  CNT_W  cycles without an edge before timeout; 0 disables timeout
o_half_period  output  CNT_W  last measured half-period in clk cycles
o_valid  output  1  o_half_period holds an unconsumed result
i_ready  input  1  consumer accepts the result when o_valid=1 and i_ready=1
o_overrun  output  1  sticky; a result was dropped because the previous one was not consumed
o_timeout  output  1  sticky; no edge seen for i_timeout_th cycles

Behaviour:
- Reset values: o_half_period=0, o_valid=0, o_overrun=0, o_timeout=0, synchronizer flops=0, counter=0, state=IDLE.
- Synchronizer: i_toggle passes through SYNC_STAGES flops, plus one more flop for edge detection.
- Edge pulse: sync_out XOR delayed copy. Both rising and falling edges count.
- Latency from an i_toggle change to its edge pulse is SYNC_STAGES+1 cycles. This latency is constant, so it cancels in the measured period.
- States: IDLE, ARM, MEAS.
- IDLE:
  - Entered whenever enable=0, from any state. enable has priority over all other events.
  - Counter, o_valid, o_overrun and o_timeout are cleared. o_half_period holds its value.
  - Moves to ARM on the first cycle enable=1.
- ARM:
  - Waits for the first edge; the counter is not running.
  - On an edge: counter loads 1, move to MEAS.
- MEAS:
  - With no edge, the counter increments and saturates at all-ones.
  - On an edge: the result equals the counter value, i.e. the number of cycles between the two edge pulses. Counter reloads 1; state stays MEAS.
- Result delivery:
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_half_period loads the result and o_valid=1.
  - If o_valid=1 and i_ready=0: the result is dropped, o_half_period is unchanged and o_overrun is set.
  - Without a new result, o_valid clears one cycle after o_valid & i_ready.
- Timeout: in MEAS with i_timeout_th!=0, when the counter reaches i_timeout_th and no edge occurs in that cycle:
  - o_timeout is set and the state goes to ARM.
  - No result is produced.
  - If an edge coincides with counter==i_timeout_th, the edge wins and a result is produced.
- Arithmetic: all compares are unsigned CNT_W-bit. Saturation prevents counter wrap-around.
- Generator check: an input from the toggle generator with threshold N measures exactly N when N≥1. Jitter of ±1 cycle is permitted only when the source is asynchronous to clk.
- Reset mid-measurement: everything returns to reset values immediately, asynchronously. The first result after reset requires two new edges.
- Flags clear only on reset or enable=0.

Decomposition:
- Shared package: state encoding constants (IDLE/ARM/MEAS) and the default CNT_W.
- One natural sub-module: sync_edge_detect, containing the SYNC_STAGES synchronizer plus the XOR edge pulse. It is reusable by other input blocks.
- The counter, FSM and output register stay in the top module.

Test Plan:
- Sync-connected toggle generator, threshold 10, i_ready=1, enable=1 → after the first two edges, o_valid pulses every 10 cycles with o_half_period=10. o_overrun=0 and o_timeout=0 throughout.
- Same source with threshold 1 → o_half_period=1 every cycle and o_valid held at 1. Checks back-to-back results with simultaneous accept and load.
- Threshold 5, i_ready=0 → the first result (5) is held and the second edge sets o_overrun=1. Raising i_ready then clears o_valid after one cycle, and the next result loads 5.
- i_timeout_th=20, input static after one edge → o_timeout=1 exactly 20 cycles after the last edge pulse and state=ARM. Edges every 7 cycles afterwards yield 7; o_timeout stays 1 until enable=0.
- Edge placed exactly at counter==i_timeout_th=8 → result 8 is produced and o_timeout stays 0.
- reset_n pulsed low, or enable=0, in mid-measurement → all outputs follow the reset/IDLE rules within one cycle (asynchronously for reset_n). The next valid result appears only after two fresh edges.
